// File: rtl/mole_round_scheduler.sv
// ============================================================================
//  Module : mole_round_scheduler
//  Brief  : Whack-a-mole game sequencer: RNG request, hit window, scoring, gap.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mole_round_scheduler #(
  parameter int NUM_MOLES    = 8,
  parameter int RNG_W        = 8,
  parameter int TIMEOUT_EASY = 50_000_000,
  parameter int TIMEOUT_HARD = 25_000_000,
  parameter int GAP_CYCLES   = 10_000_000,
  parameter int ROUNDS       = 30,
  parameter int SCORE_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 level_select,
  input  logic [NUM_MOLES-1:0] switches,
  output logic                 rng_req,
  input  logic                 rng_valid,
  input  logic [RNG_W-1:0]     rng_value,
  output logic [NUM_MOLES-1:0] leds,
  output logic [SCORE_W-1:0]   points,
  output logic [SCORE_W-1:0]   misses,
  output logic                 busy,
  output logic                 game_over
);

  localparam int c_IDX_W = $clog2(NUM_MOLES);
  localparam int c_WMAX  = (TIMEOUT_EASY > TIMEOUT_HARD) ? TIMEOUT_EASY : TIMEOUT_HARD;
  localparam int c_TMAX  = (c_WMAX > GAP_CYCLES) ? c_WMAX : GAP_CYCLES;
  localparam int c_TW    = $clog2(c_TMAX + 1);
  localparam int c_RW    = $clog2(ROUNDS + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_SHOW = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t               state_q;
  logic [NUM_MOLES-1:0] prev_sw_q;
  logic [NUM_MOLES-1:0] leds_q;
  logic                 rng_req_q;
  logic [SCORE_W-1:0]   points_q;
  logic [SCORE_W-1:0]   misses_q;
  logic [c_RW-1:0]      round_q;
  logic [c_IDX_W-1:0]   last_q;
  logic [c_TW-1:0]      window_q;
  logic [c_TW-1:0]      timer_q;

  logic [NUM_MOLES-1:0] w_edge;
  logic                 w_hit;
  logic                 w_wrong;
  logic                 w_expire;
  logic [c_IDX_W-1:0]   w_idx_raw;
  logic [c_IDX_W-1:0]   w_idx;
  logic [SCORE_W-1:0]   w_points_inc;
  logic [SCORE_W-1:0]   w_points_dec;
  logic [SCORE_W-1:0]   w_misses_inc;

  // The lit LED doubles as the target mask, so hit/wrong need no index decode.
  assign w_edge    = switches & ~prev_sw_q;
  assign w_hit     = |(w_edge & leds_q);
  assign w_wrong   = |(w_edge & ~leds_q);
  assign w_expire  = (timer_q == c_TW'(1));
  assign w_idx_raw = c_IDX_W'(rng_value % NUM_MOLES);
  assign w_idx     = (w_idx_raw == last_q) ? w_idx_raw + 1'b1 : w_idx_raw;

  assign w_points_inc = (&points_q) ? points_q : points_q + 1'b1;
  assign w_points_dec = (points_q == '0) ? points_q : points_q - 1'b1;
  assign w_misses_inc = (&misses_q) ? misses_q : misses_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      prev_sw_q <= '0;
      leds_q    <= '0;
      rng_req_q <= 1'b0;
      points_q  <= '0;
      misses_q  <= '0;
      round_q   <= '0;
      last_q    <= '0;
      window_q  <= '0;
      timer_q   <= '0;
    end else begin
      prev_sw_q <= switches;
      if (abort) begin
        state_q   <= S_IDLE;
        leds_q    <= '0;
        rng_req_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (start) begin
              points_q  <= '0;
              misses_q  <= '0;
              round_q   <= '0;
              window_q  <= level_select ? c_TW'(TIMEOUT_HARD) : c_TW'(TIMEOUT_EASY);
              rng_req_q <= 1'b1;
              state_q   <= S_REQ;
            end
          end
          S_REQ: begin
            if (rng_valid) begin
              last_q    <= w_idx;
              timer_q   <= window_q;
              leds_q    <= NUM_MOLES'(1) << w_idx;
              rng_req_q <= 1'b0;
              state_q   <= S_SHOW;
            end
          end
          S_SHOW: begin
            if (w_hit) begin
              points_q <= w_points_inc;
            end else if (w_wrong) begin
              points_q <= w_points_dec;
            end
            if (!w_hit && w_expire) begin
              misses_q <= w_misses_inc;
            end
            if (w_hit || w_expire) begin
              leds_q  <= '0;
              round_q <= round_q + 1'b1;
              timer_q <= c_TW'(GAP_CYCLES);
              state_q <= S_GAP;
            end else begin
              timer_q <= timer_q - 1'b1;
            end
          end
          S_GAP: begin
            if (w_expire) begin
              if (round_q == c_RW'(ROUNDS)) begin
                state_q <= S_DONE;
              end else begin
                rng_req_q <= 1'b1;
                state_q   <= S_REQ;
              end
            end else begin
              timer_q <= timer_q - 1'b1;
            end
          end
          default: begin
            state_q   <= S_IDLE;
            leds_q    <= '0;
            rng_req_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rng_req   = rng_req_q;
  assign leds      = leds_q;
  assign points    = points_q;
  assign misses    = misses_q;
  assign busy      = (state_q == S_REQ) || (state_q == S_SHOW) || (state_q == S_GAP);
  assign game_over = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_mole_round_scheduler.sv
// ============================================================================
//  Module : tb_mole_round_scheduler
//  Brief  : Directed + randomized game sequences against a per-mole score model.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mole_round_scheduler;

  localparam int NM = 4;
  localparam int TE = 8;
  localparam int TH = 4;
  localparam int GC = 2;
  localparam int RD = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        level_select;
  logic [3:0]  switches;
  logic        rng_req;
  logic        rng_valid;
  logic [7:0]  rng_value;
  logic [3:0]  leds;
  logic [15:0] points;
  logic [15:0] misses;
  logic        busy;
  logic        game_over;

  mole_round_scheduler #(
    .NUM_MOLES   (NM),
    .RNG_W       (8),
    .TIMEOUT_EASY(TE),
    .TIMEOUT_HARD(TH),
    .GAP_CYCLES  (GC),
    .ROUNDS      (RD),
    .SCORE_W     (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .level_select(level_select),
    .switches    (switches),
    .rng_req     (rng_req),
    .rng_valid   (rng_valid),
    .rng_value   (rng_value),
    .leds        (leds),
    .points      (points),
    .misses      (misses),
    .busy        (busy),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Game-level model: last mole index, score, misses, rounds played, window.
  int m_last   = 0;
  int m_points = 0;
  int m_misses = 0;
  int m_round  = 0;
  int m_window = TE;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game(input int lvl);
    level_select = lvl[0];
    start = 1'b1;
    tick();
    start = 1'b0;
    level_select = 1'($urandom);
    m_points = 0;
    m_misses = 0;
    m_round  = 0;
    m_window = (lvl != 0) ? TH : TE;
    chk("start_busy", busy, 1);
    chk("start_req", rng_req, 1);
    chk("start_points", points, 0);
    chk("start_misses", misses, 0);
    chk("start_over", game_over, 0);
  endtask

  // One mole: handshake, SHOW window with optional hit / wrong edges, GAP.
  task automatic play_mole(input int rv, input int hit_at, input int wrong_at, input int hold);
    int         idx;
    logic [3:0] mask;
    logic [3:0] wmask;
    logic [3:0] sw;
    bit         got_hit;
    idx = rv % NM;
    if (idx == m_last) idx = (idx + 1) % NM;
    m_last = idx;
    mask  = 4'(1 << idx);
    wmask = 4'($urandom_range(1, 15)) & ~mask;
    if (wmask == 4'h0) wmask = ~mask;

    chk("req_high", rng_req, 1);
    rng_value = rv[7:0];
    rng_valid = 1'b1;
    tick();
    rng_valid = 1'b0;
    rng_value = 8'($urandom);

    got_hit = 1'b0;
    for (int c = 1; c <= m_window && !got_hit; c++) begin
      chk("led_on", leds, mask);
      if (c == 1) chk("req_drop", rng_req, 0);
      sw = 4'h0;
      if (c == wrong_at || (hold != 0 && wrong_at != 0 && c > wrong_at)) sw = sw | wmask;
      if (c == hit_at) sw = sw | mask;
      switches = sw;
      if (c == hit_at) begin
        if (m_points != 65535) m_points++;
        got_hit = 1'b1;
      end else begin
        if (c == wrong_at && m_points > 0) m_points--;
        if (c == m_window) m_misses++;
      end
      tick();
    end

    for (int g = 1; g <= GC; g++) begin
      if (g == 1) begin
        chk("gap_leds", leds, 0);
        chk("gap_points", points, m_points);
        chk("gap_misses", misses, m_misses);
        chk("gap_busy", busy, 1);
        chk("gap_req", rng_req, 0);
        switches = 4'($urandom);
        start    = 1'($urandom);
      end else begin
        switches = 4'h0;
        start    = 1'b0;
      end
      tick();
    end
    switches = 4'h0;
    start    = 1'b0;
    m_round++;
    if (m_round == RD) begin
      chk("end_over", game_over, 1);
      chk("end_busy", busy, 0);
      chk("end_leds", leds, 0);
    end else begin
      chk("next_req", rng_req, 1);
      chk("next_over", game_over, 0);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    level_select = 1'b0;
    switches     = 4'h0;
    rng_valid    = 1'b0;
    rng_value    = 8'h0;
    #12;
    chk("rst_leds", leds, 0);
    chk("rst_req", rng_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_over", game_over, 0);
    chk("rst_points", points, 0);
    chk("rst_misses", misses, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // Easy game, rng_value=1 three times: moles 1,2,1; last mole hit+wrong on final cycle.
    start_game(0);
    play_mole(1, 2, 0, 0);
    play_mole(1, 0, 0, 0);
    play_mole(1, TE, TE, 0);
    chk("gameA_points", points, 2);
    chk("gameA_misses", misses, 1);

    // Hard game: miss, wrong-at-zero with held switch then hit, wrong after hit.
    start_game(1);
    play_mole(6, 0, 0, 0);
    play_mole(3, 3, 1, 1);
    play_mole(5, 0, 2, 0);
    chk("gameB_points", points, 0);
    chk("gameB_misses", misses, 2);

    // Abort coinciding with an RNG handshake and a start pulse.
    start_game(0);
    play_mole(int'($urandom_range(0, 255)), 1, 0, 0);
    abort     = 1'b1;
    rng_valid = 1'b1;
    rng_value = 8'($urandom);
    start     = 1'b1;
    tick();
    abort     = 1'b0;
    rng_valid = 1'b0;
    start     = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_req", rng_req, 0);
    chk("abort_leds", leds, 0);
    chk("abort_over", game_over, 0);
    chk("abort_points", points, 1);
    chk("abort_misses", misses, 0);
    tick();
    chk("abort_idle", busy, 0);

    // Randomized games.
    for (int g = 0; g < 6; g++) begin
      start_game(int'($urandom_range(0, 1)));
      for (int r = 0; r < RD; r++) begin
        play_mole(int'($urandom_range(0, 255)), int'($urandom_range(0, m_window)),
                  int'($urandom_range(0, m_window)), int'($urandom_range(0, 1)));
      end
    end

    // Asynchronous reset in the middle of SHOW.
    start_game(0);
    play_mole(int'($urandom_range(0, 255)), 2, 0, 0);
    rng_value = 8'($urandom);
    rng_valid = 1'b1;
    tick();
    rng_valid = 1'b0;
    tick();
    chk("pre_rst_lit", (leds != 4'h0) ? 1 : 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_leds", leds, 0);
    chk("arst_points", points, 0);
    chk("arst_misses", misses, 0);
    chk("arst_req", rng_req, 0);
    #3;
    rst_n = 1'b1;
    m_last = 0;
    m_points = 0;
    m_misses = 0;
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_over", game_over, 0);
    start_game(1);
    play_mole(0, 0, 0, 0);
    play_mole(int'($urandom_range(0, 255)), 1, 0, 0);
    play_mole(int'($urandom_range(0, 255)), 0, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mole_round_scheduler.md
Name: mole_round_scheduler

Overview:
- Sequences a full whack-a-mole game across NUM_MOLES LED/switch pairs.
- Requests a random mole index from the RNG over a req/valid handshake, lights one LED and runs the per-level hit window.
- Scores hits, misses and wrong-switch penalties, inserts a dark gap between moles, and ends the game after ROUNDS moles.
- Sits between the debounced button/switch inputs, the RNG block and the LED/score display.

Parameters:
NUM_MOLES, 8, number of LED/switch pairs (power of 2, >=2)
RNG_W, 8, width of rng_value (>= clog2(NUM_MOLES))
TIMEOUT_EASY, 50_000_000, hit window in cycles when level_select=0
TIMEOUT_HARD, 25_000_000, hit window in cycles when level_select=1
GAP_CYCLES, 10_000_000, dark cycles between moles (>=1)
ROUNDS, 30, moles per game (>=1)
SCORE_W, 16, width of points and misses

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; starts a game from IDLE or DONE
abort  in  1  single-cycle pulse; returns to IDLE from any state
level_select  in  1  0=easy, 1=hard; sampled only on accepted start
switches  in  NUM_MOLES  debounced switch levels
rng_req  out  1  request for a random value
rng_valid  in  1  rng_value valid; transfer when rng_req&rng_valid
rng_value  in  RNG_W  random value
leds  out  NUM_MOLES  one-hot active mole, zero otherwise
points  out  SCORE_W  hit score
misses  out  SCORE_W  missed-mole count
busy  out  1  high in REQ/SHOW/GAP
game_over  out  1  high in DONE

Behaviour:
- Reset values: state=IDLE; leds, rng_req, busy, game_over = 0; points, misses, round count = 0; last index = 0; switch history = 0.
- Switch edges: prev_sw is registered every cycle in every state. edge = switches & ~prev_sw. Only edges count; held switches never re-trigger.
- States: IDLE, REQ, SHOW, GAP, DONE.
- IDLE, start=1:
  - Clear points, misses and round count.
  - Latch the window: TIMEOUT_HARD if level_select=1, else TIMEOUT_EASY.
  - Go to REQ.
- REQ:
  - rng_req=1, held until handshake; rng_req is registered and asserts on the first REQ cycle.
  - On rng_valid: idx = rng_value mod NUM_MOLES (low bits). If idx == last index, use (idx+1) mod NUM_MOLES.
  - Store idx as the last index, load timer with the window, go to SHOW.
  - rng_req drops on the cycle SHOW is entered.
- SHOW:
  - leds = 1<<idx from the first SHOW cycle. Timer decrements each cycle.
  - Hit: edge[idx]=1. points+1, saturating at all-ones. Go to GAP.
  - Wrong switch: any edge outside idx with no hit that cycle. points-1, saturating at 0; stay in SHOW, timer unaffected. Several wrong edges in one cycle give a single -1.
  - Miss: no hit on the cycle timer==1, i.e. the window-th SHOW cycle. misses+1, saturating. Go to GAP.
  - Hit beats wrong switch and miss in the same cycle.
  - SHOW lasts exactly window cycles without a hit.
- GAP:
  - On entry: leds=0, round count+1, timer=GAP_CYCLES.
  - Lasts exactly GAP_CYCLES cycles; switch edges are ignored.
  - At expiry: DONE if round count==ROUNDS, else REQ.
- DONE: game_over=1, leds=0, points and misses held. start begins a new game exactly as from IDLE.
- abort:
  - From any state, abort goes to IDLE on the next edge: leds=0, rng_req=0, busy=0. points and misses are held.
  - abort has priority over every other transition. start in the same cycle as abort is ignored.
  - An RNG handshake completing in the abort cycle is discarded.
- start outside IDLE/DONE is ignored. level_select changes mid-game have no effect.
- rst_n low in any state forces the reset values immediately, independent of clk.

Test Plan:
All scenarios use NUM_MOLES=4, TIMEOUT_EASY=8, TIMEOUT_HARD=4, GAP_CYCLES=2, ROUNDS=3.
1. Easy hit: start with level_select=0; rng_valid=1 with rng_value=6 on the first REQ cycle -> leds=4'b0100 the next cycle; switches[2] pulse on SHOW cycle 3 -> points=1, leds=0 for 2 cycles, then rng_req=1.
2. Hard miss: start with level_select=1; no switch activity -> leds lit for exactly 4 cycles; misses=1, points=0; rng_req reasserts 2 cycles after the LED drops.
3. Repeat avoidance and full game: rng_value=1 for three consecutive moles -> leds 0010, 0100, 0010. After the third GAP, game_over=1 and busy=0; a new start clears points and misses.
4. Wrong switch and saturation:
   - switches[0] edge while mole 3 is lit at points=0 -> points stays 0, mole stays lit.
   - After a hit (points=1), a wrong edge -> points=0.
   - A held switch produces only one event.
5. Simultaneous events: edge on idx and a wrong switch on the final window cycle -> points+1, misses unchanged. abort together with rng_valid -> IDLE, leds=0, score held.
6. Reset mid-game: rst_n=0 asynchronously during SHOW -> leds, points, misses, rng_req = 0 before the next clk edge; state=IDLE after release.
